// File: rtl/mem_pkg.sv
// Shared types and defaults for the pipelined data memory.
package mem_pkg;

  localparam logic [31:0] DATA_START_DEFAULT = 32'h1000_0000;
  localparam logic [31:0] INIT_VALUE_DEFAULT = 32'hdead_beef;
  localparam int unsigned DATA_W             = 32;
  localparam int unsigned BE_W               = DATA_W / 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    logic              fault;
    logic [DATA_W-1:0] rdata;
  } resp_t;

  // Word-index width for a segment of the given depth.
  function automatic int unsigned addr_bits(input int unsigned words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-depth shift register carrying responses from the accept edge to the port.
module mem_resp_pipe
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  resp_t resp_i,
  output resp_t resp_o
);

  resp_t stage_q [DEPTH];

  // Reset clears whole stages so idle outputs stay at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= resp_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign resp_o = stage_q[DEPTH-1];

endmodule

// File: rtl/data_mem_pipelined.sv
// Word-addressed data segment with byte-enable stores, range/alignment faults,
// post-reset fill sequencer and a fixed read latency.
module data_mem_pipelined
  import mem_pkg::*;
#(
  parameter logic [31:0] DATA_START   = DATA_START_DEFAULT,
  parameter int unsigned ADDR_WORDS   = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] INIT_VALUE   = INIT_VALUE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic              busy
);

  localparam int unsigned AW       = addr_bits(ADDR_WORDS);
  localparam logic [32:0] SEG_BASE = {1'b0, DATA_START};
  localparam logic [32:0] SEG_END  = SEG_BASE + (33'(ADDR_WORDS) << 2);
  localparam logic [AW-1:0] LAST_IDX = AW'(ADDR_WORDS - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            init_we_c;
  logic            accept_c;
  logic            in_range_c;
  logic            fault_c;
  logic            store_we_c;
  logic [AW-1:0]   idx_c;
  logic [DATA_W-1:0] mem_q [ADDR_WORDS];
  resp_t           pipe_in_c;
  resp_t           pipe_out;

  // State and fill-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk every word once, then stay in RUN until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    init_we_c = 1'b0;
    case (state_q)
      INIT: begin
        busy      = 1'b1;
        init_we_c = 1'b1;
      end
      RUN: begin
        req_ready = 1'b1;
      end
    endcase
  end

  // Request decode; the 33-bit compare keeps overflowing addresses out of range.
  always_comb begin
    idx_c      = req_addr[AW+1:2];
    in_range_c = ({1'b0, req_addr} >= SEG_BASE) && ({1'b0, req_addr} < SEG_END);
    fault_c    = !in_range_c || (req_addr[1:0] != 2'b00);
    accept_c   = req_valid && req_ready;
    store_we_c = accept_c && req_write && !fault_c;

    pipe_in_c       = '0;
    pipe_in_c.valid = accept_c;
    pipe_in_c.fault = accept_c && fault_c;
    if (accept_c && !req_write && !fault_c) begin
      pipe_in_c.rdata = mem_q[idx_c];
    end
  end

  // Array is not reset; the fill sequencer owns it until RUN.
  always_ff @(posedge clk) begin
    if (init_we_c) begin
      mem_q[cnt_q] <= INIT_VALUE;
    end else if (store_we_c) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) begin
          mem_q[idx_c][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  mem_resp_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_resp_pipe (
    .clk    (clk),
    .rst_n  (reset),
    .resp_i (pipe_in_c),
    .resp_o (pipe_out)
  );

  assign resp_valid = pipe_out.valid;
  assign resp_fault = pipe_out.fault;
  assign resp_rdata = pipe_out.rdata;

endmodule

// File: tb/tb_data_mem_pipelined.sv
// Scoreboard bench: four instances (latency 1..4, 16 words) share one stimulus stream.
module tb_data_mem_pipelined;

  localparam int unsigned NI = 4;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be    = '0;
  logic [31:0] exp_data  = '0;
  logic        exp_fault = 1'b0;

  logic [NI-1:0] rdy, rv, rf, bsy;
  logic [31:0]   rd [NI];

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int unsigned edge_n;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] ed;
    logic        ef;
  } vec_t;

  exp_t        sb_q [NI][$];
  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  vec_t vecs [18] = '{
    '{1'b0, 32'h1000_0004, 32'h0,         4'h0, 32'hdead_beef, 1'b0},
    '{1'b1, 32'h1000_0008, 32'h1122_3344, 4'hF, 32'h0,         1'b0},
    '{1'b1, 32'h1000_0008, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0},
    '{1'b0, 32'h1000_0008, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0},
    '{1'b0, 32'h0FFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1},
    '{1'b0, 32'h1000_0040, 32'h0,         4'h0, 32'h0,         1'b1},
    '{1'b0, 32'h1000_0002, 32'h0,         4'h0, 32'h0,         1'b1},
    '{1'b0, 32'h1000_0000, 32'h0,         4'h0, 32'hdead_beef, 1'b0},
    '{1'b1, 32'h1000_000C, 32'h0102_0304, 4'hF, 32'h0,         1'b0},
    '{1'b0, 32'h1000_000C, 32'h0,         4'h0, 32'h0102_0304, 1'b0},
    '{1'b1, 32'h1000_0010, 32'hCAFE_F00D, 4'h0, 32'h0,         1'b0},
    '{1'b0, 32'h1000_0010, 32'h0,         4'h0, 32'hdead_beef, 1'b0},
    '{1'b1, 32'h1000_003C, 32'h5566_7788, 4'h8, 32'h0,         1'b0},
    '{1'b0, 32'h1000_003C, 32'h0,         4'h0, 32'h55AD_BEEF, 1'b0},
    '{1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'hF, 32'h0,         1'b1},
    '{1'b0, 32'h1000_003C, 32'h0,         4'h0, 32'h55AD_BEEF, 1'b0},
    '{1'b1, 32'h1000_0006, 32'h9999_9999, 4'hF, 32'h0,         1'b1},
    '{1'b0, 32'h1000_0004, 32'h0,         4'h0, 32'hdead_beef, 1'b0}
  };

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      data_mem_pipelined #(
        .DATA_START   (32'h1000_0000),
        .ADDR_WORDS   (16),
        .READ_LATENCY (g + 1),
        .INIT_VALUE   (32'hdead_beef)
      ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (rdy[g]),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (rv[g]),
        .resp_rdata (rd[g]),
        .resp_fault (rf[g]),
        .busy       (bsy[g])
      );
    end
  endgenerate

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send(input vec_t v);
    int n = 0;
    req_valid = 1'b1;
    req_write = v.w;
    req_addr  = v.a;
    req_wdata = v.d;
    req_be    = v.be;
    exp_data  = v.ed;
    exp_fault = v.ef;
    while (!rdy[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[0]) begin
      check("send_ready_timeout", {31'b0, rdy[0]}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_init();
    int n = 0;
    while (bsy[0] && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("init_cycles", 32'(n), 32'd16);
    check("ready_after_init", {28'b0, rdy}, 32'hF);
    check("busy_after_init", {28'b0, bsy}, 32'h0);
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, "_resp_valid"}, {28'b0, rv}, 32'h0);
    check({tag, "_resp_fault"}, {28'b0, rf}, 32'h0);
    check({tag, "_ready"}, {28'b0, rdy}, 32'h0);
    check({tag, "_busy"}, {28'b0, bsy}, 32'hF);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_rdata_L%0d", tag, i + 1), rd[i], 32'h0);
    end
  endtask

  initial begin
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(posedge clk or negedge clk or negedge reset);
          if (!reset) begin
            for (int i = 0; i < NI; i++) sb_q[i].delete();
          end else if (clk) begin
            if (req_valid && rdy[0]) begin
              for (int i = 0; i < NI; i++) sb_q[i].push_back('{exp_data, exp_fault, cyc});
            end
            cyc++;
          end else begin
            for (int i = 0; i < NI; i++) begin
              if (rv[i]) begin
                if (sb_q[i].size() == 0) begin
                  check($sformatf("unexpected_resp_L%0d", i + 1), {31'b0, rv[i]}, 32'h0);
                end else begin
                  e = sb_q[i].pop_front();
                  check($sformatf("rdata_L%0d", i + 1), rd[i], e.data);
                  check($sformatf("fault_L%0d", i + 1), {31'b0, rf[i]}, {31'b0, e.fault});
                  check($sformatf("latency_L%0d", i + 1), 32'(cyc - e.edge_n), 32'(i + 1));
                end
              end else begin
                check($sformatf("idle_zero_L%0d", i + 1), rd[i] | {31'b0, rf[i]}, 32'h0);
              end
            end
          end
        end
      end
    join_none

    #2 reset = 1'b0;
    #1 check_in_reset("por");
    @(negedge clk);
    #1 reset = 1'b1;
    wait_init();

    foreach (vecs[i]) send(vecs[i]);
    repeat (8) @(negedge clk);

    // Load in flight when reset hits: only the latency-1 copy has already answered.
    send('{1'b0, 32'h1000_0008, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0});
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_in_reset("mid");
    #1 reset = 1'b1;
    wait_init();

    send('{1'b0, 32'h1000_0008, 32'h0, 4'h0, 32'hdead_beef, 1'b0});
    send('{1'b0, 32'h1000_003C, 32'h0, 4'h0, 32'hdead_beef, 1'b0});
    send('{1'b0, 32'h1000_000C, 32'h0, 4'h0, 32'hdead_beef, 1'b0});
    repeat (10) @(negedge clk);

    for (int i = 0; i < NI; i++) begin
      check($sformatf("queue_drained_L%0d", i + 1), 32'(sb_q[i].size()), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_pipelined.md
Name: data_mem_pipelined

Overview:
Parametrised successor to the single-cycle data memory. It is a word-addressed data segment with a valid/ready request port, per-byte write enables and a configurable read latency. It also raises a fault flag on out-of-range or misaligned accesses. A built-in init sequencer fills the array with a known pattern after reset, so the datapath never reads X. It sits between the CPU memory stage and the data segment.

Parameters:
DATA_START, 32'h1000_0000, byte base address of segment; must be aligned to ADDR_WORDS*4
ADDR_WORDS, 1024, segment depth in 32-bit words; power of 2, 2..2^20
READ_LATENCY, 2, cycles from request acceptance to response; legal 1..4
INIT_VALUE, 32'hdeadbeef, fill value written to every word after reset

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-low reset; 0 = in reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data
req_be  in  4  byte-lane write enables; lane i = bits [8i+7:8i]
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  32  load data; 0 for stores and faults
resp_fault  out  1  access was out of range or misaligned
busy  out  1  init sequence in progress

Behaviour:
- Accept = req_valid & req_ready at a rising edge. One request may be accepted per cycle; there is no response backpressure.
- Index = req_addr[AW+1:2], where AW = clog2(ADDR_WORDS).
- in_range = (req_addr >= DATA_START) && (req_addr < DATA_START + ADDR_WORDS*4).
- fault = !in_range || (req_addr[1:0] != 0).
- FSM states:
  - INIT: counter walks 0..ADDR_WORDS-1, writing INIT_VALUE to one word per cycle. Leaves for RUN at the edge where counter == ADDR_WORDS-1, so INIT lasts exactly ADDR_WORDS cycles.
  - RUN: terminal state until the next reset.
- req_ready = (state == RUN); busy = (state == INIT).
- Reset asserted (async):
  - state = INIT, counter = 0, all pipeline valid bits cleared.
  - resp_valid = 0, resp_rdata = 0, resp_fault = 0, req_ready = 0, busy = 1.
  - Array contents are not reset; they are refilled by INIT.
- Reset asserted mid-INIT or mid-transaction: in-flight responses are dropped, never emitted, and INIT restarts from word 0.
- Store, no fault: at the accept edge, lanes with req_be[i]=1 are written and other lanes are kept. req_be = 0 is a legal no-op store that still responds.
- Load, no fault: the array is read at the accept edge. The load sees every store accepted in earlier cycles, never a store accepted in the same cycle; only one request exists per cycle, so this cannot occur.
- Fault: no array write; resp_rdata = 0, resp_fault = 1.
- Response for a request accepted at edge k: resp_valid = 1 for exactly one cycle, the cycle after edge k+READ_LATENCY-1.
  - READ_LATENCY = 1 gives a response in the cycle immediately after the accept edge.
  - Back-to-back accepts give back-to-back responses, in order.
- Outside response cycles: resp_rdata and resp_fault are 0.
- Address wrap-around: none. Addresses at or above DATA_START + ADDR_WORDS*4, including 32-bit overflow values, fault.

Decomposition:
- Package mem_pkg holds:
  - default constants DATA_START_DEFAULT and INIT_VALUE_DEFAULT
  - the FSM state typedef {INIT, RUN}
  - the function that computes AW from ADDR_WORDS
- Sub-module mem_resp_pipe: a READ_LATENCY-deep shift register of {valid, fault, rdata}.
  - Async active-low clear of the valid bits.
  - The top level instantiates it once.

Test Plan:
1. Release reset with ADDR_WORDS=16 -> busy=1 and req_ready=0 for exactly 16 cycles, then req_ready=1. A load of 0x10000004 returns 0xdeadbeef, fault 0, 2 cycles after accept.
2. Store 0x11223344 to 0x10000008 with be=4'b1111, then store 0xAABBCCDD with be=4'b0101, then load -> 0x11BB33DD.
3. Loads to 0x0FFFFFFC, 0x10000040 (ADDR_WORDS=16) and 0x10000002 -> resp_fault=1, rdata=0. A following load of 0x10000000 shows the array unchanged.
4. Store at edge k, load of the same address at edge k+1, with READ_LATENCY=3 -> two consecutive resp_valid pulses at cycles k+3 and k+4; the load returns the new data.
5. Assert reset while a load is 1 cycle into a 2-cycle latency -> no resp_valid is ever emitted for it. INIT restarts and takes the full ADDR_WORDS cycles; previously stored data reads back as 0xdeadbeef.
6. Sweep READ_LATENCY 1..4 with 8 back-to-back mixed requests -> responses arrive in order, each exactly READ_LATENCY cycles after acceptance.
